rb_packed_pixel_fifo: RTL and testbench
=======================================

# rb_packed_pixel_fifo

- Parametrised, flow-controlled successor to the row-buffer BRAM: an asymmetric circular buffer.
- Accepts one pixel per cycle on a narrow write port.
- Delivers packed words of RBS consecutive pixels on a wide read port.
- Sits between the pixel stream source and the neighbourhood-processing window logic; backpressure on both sides replaces the free-running address ports.

## Interface
Parameters:
- PIXEL_WIDTH, 8, bits per pixel
- RBS, 4, pixels per read word (≥1)
- DEPTH, 1024, storage in pixels; power of two, multiple of RBS

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset; asynchronous assert, active-low
- FLUSH  in  1  synchronous clear
- WR_VALID  in  1  pixel offered
- WR_READY  out  1  pixel can be accepted
- WR_DATA  in  PIXEL_WIDTH  pixel
- RD_VALID  out  1  RD_DATA holds a word
- RD_READY  in  1  consumer takes the word
- RD_DATA  out  RBS*PIXEL_WIDTH  packed word
- LEVEL  out  $clog2(DEPTH)+1  pixels stored in memory, excluding the output register
- OVERFLOW  out  1  sticky write-while-full flag (see Configuration)

## Operation
- Write accept: WR_VALID && WR_READY at a rising edge.
  - Pixel is stored at wptr.
  - wptr advances by 1, modulo DEPTH.
- WR_READY = (LEVEL < DEPTH), combinational; forced 0 while RST_N low.
- Read issue condition: LEVEL ≥ RBS && (!RD_VALID || RD_READY).
- On read issue, at the same edge:
  - Memory word rptr/RBS is loaded into the RD_DATA register.
  - RD_VALID is set.
  - rptr advances by RBS, modulo DEPTH.
- Packing: pixel at rptr+i goes to RD_DATA[i*PIXEL_WIDTH +: PIXEL_WIDTH]. Oldest pixel sits in the LSBs.
- Pop (RD_VALID && RD_READY) with no new issue: RD_VALID clears; RD_DATA holds its last value.
- LEVEL update per edge: +1 on write accept, −RBS on read issue, both when simultaneous (net 1−RBS).
- rptr always stays RBS-aligned. Read and write never address the same slot in one cycle, so no bypass path is needed.
- FLUSH (sync) has priority over the write and read of that cycle. At the next edge:
  - wptr = rptr = 0, LEVEL = 0
  - RD_VALID = 0, OVERFLOW = 0
  - RD_DATA is unchanged
  - memory contents are not cleared
- Reset values (RST_N low):
  - wptr = rptr = 0, LEVEL = 0
  - RD_VALID = 0, RD_DATA = 0, OVERFLOW = 0, WR_READY = 0
  - memory is not reset
- Total capacity is DEPTH + RBS pixels: DEPTH in memory plus RBS in the output register.

## Timing
- Latency: if the RBS-th pixel of a word is accepted at edge E and the output register is free, RD_VALID = 1 after edge E+1.
- Throughput:
  - one pixel per cycle in
  - one word per cycle out when LEVEL ≥ RBS and RD_READY is held high
- Memory read is synchronous into the RD_DATA register. No combinational path from memory to the outputs.
- WR_READY depends only on registered LEVEL, not on RD_READY in the same cycle.
- Reset asserted mid-transfer: every pointer and flag clears immediately, asynchronously. The first accept is possible on the first edge after RST_N deasserts.

## Configuration
- Macro RB_FIFO_OVERFLOW_FLAG_EN.
- Defined:
  - OVERFLOW sets at any edge where WR_VALID = 1 and WR_READY = 0.
  - It stays set until FLUSH or reset.
- Undefined: OVERFLOW is tied to 0 and no flag logic is built.
- Data path behaviour is identical either way.

## Test plan
All tests use PIXEL_WIDTH=8, RBS=4, DEPTH=16.
- Reset: drive RST_N low mid-stream → immediately RD_VALID=0, RD_DATA=0, LEVEL=0, WR_READY=0. After release, WR_READY=1.
- Packing/latency: with RD_READY=1, write 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after the 4th accept, RD_VALID=1, RD_DATA=0x44332211, LEVEL=0.
- Full: with RD_READY=0, stream incrementing pixels → exactly 20 accepted, then WR_READY=0 and LEVEL=16. One pop → WR_READY stays 0 until the refill issue, then reaches 1 with LEVEL=12.
- Wrap/backpressure: stream 0x00..0x2F with random WR_VALID and RD_READY → 12 words in order, 0x03020100 through 0x2F2E2D2C, with no loss or duplication.
- FLUSH: assert after 6 accepts while WR_VALID=1 → next edge LEVEL=0 and RD_VALID=0, and the flush-cycle pixel is dropped. The next 4 pixels come out as one word.
- Overflow: with the macro defined, hold WR_VALID=1 while full → OVERFLOW=1 and stays 1 after draining; FLUSH clears it. With the macro undefined, OVERFLOW stays 0 throughout.

Source files
------------

// File: rtl/rb_packed_pixel_fifo.sv
// rtl/rb_packed_pixel_fifo.sv - asymmetric pixel FIFO, one pixel in, RBS-pixel packed word out.
// Optional sticky overflow flag built only when RB_FIFO_OVERFLOW_FLAG_EN is defined.
module rb_packed_pixel_fifo #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RBS         = 4,
  parameter int DEPTH       = 1024
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         FLUSH,
  input  logic                         WR_VALID,
  output logic                         WR_READY,
  input  logic [PIXEL_WIDTH-1:0]       WR_DATA,
  output logic                         RD_VALID,
  input  logic                         RD_READY,
  output logic [RBS*PIXEL_WIDTH-1:0]   RD_DATA,
  output logic [$clog2(DEPTH):0]       LEVEL,
  output logic                         OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PIXEL_WIDTH-1:0]     r_mem [DEPTH];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [LW-1:0]              r_level;
  logic                       r_rd_valid;
  logic [RBS*PIXEL_WIDTH-1:0] r_rd_data;

  logic                       w_wr_acc;
  logic                       w_rd_iss;
  logic                       w_wr_en;
  logic [RBS*PIXEL_WIDTH-1:0] w_rd_word;
  logic [LW-1:0]              w_level_nxt;

  assign WR_READY = RST_N && (r_level < LW'(DEPTH));
  assign w_wr_acc = WR_VALID && WR_READY;
  assign w_rd_iss = (r_level >= LW'(RBS)) && (!r_rd_valid || RD_READY);
  // Flush drops the pixel offered in the same cycle, so it must not land in memory either.
  assign w_wr_en  = w_wr_acc && !FLUSH;

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < RBS; i++) begin
      w_rd_word[i*PIXEL_WIDTH +: PIXEL_WIDTH] = r_mem[r_rptr + AW'(i)];
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc) w_level_nxt = w_level_nxt + LW'(1);
    if (w_rd_iss) w_level_nxt = w_level_nxt - LW'(RBS);
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (FLUSH) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_iss) begin
        r_rd_data  <= w_rd_word;
        r_rd_valid <= 1'b1;
        r_rptr     <= r_rptr + AW'(RBS);
      end else if (r_rd_valid && RD_READY) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

`ifdef RB_FIFO_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflow <= 1'b0;
    end else if (FLUSH) begin
      r_overflow <= 1'b0;
    end else if (WR_VALID && !WR_READY) begin
      r_overflow <= 1'b1;
    end
  end

  assign OVERFLOW = r_overflow;
`else
  assign OVERFLOW = 1'b0;
`endif

  assign RD_VALID = r_rd_valid;
  assign RD_DATA  = r_rd_data;
  assign LEVEL    = r_level;

endmodule

// File: tb/tb_rb_packed_pixel_fifo.sv
// tb/tb_rb_packed_pixel_fifo.sv - table vectors plus word scoreboard for rb_packed_pixel_fifo.
module tb_rb_packed_pixel_fifo;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic        WR_VALID;
  logic        WR_READY;
  logic [7:0]  WR_DATA;
  logic        RD_VALID;
  logic        RD_READY;
  logic [31:0] RD_DATA;
  logic [4:0]  LEVEL;
  logic        OVERFLOW;

`ifdef RB_FIFO_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  rb_packed_pixel_fifo #(.PIXEL_WIDTH(8), .RBS(4), .DEPTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fails  = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0]  pix_q[$];
  logic [31:0] word_q[$];

  always @(negedge CLK) begin
    if (!RST_N || FLUSH) begin
      pix_q.delete();
      word_q.delete();
    end else begin
      if (RD_VALID && RD_READY) begin
        n_pops++;
        if (word_q.size() == 0) begin
          check("sb_unexpected_word", {32'h0, RD_DATA}, 64'hDEAD);
        end else begin
          check("sb_word", {32'h0, RD_DATA}, {32'h0, word_q.pop_front()});
        end
      end
      if (WR_VALID && WR_READY) begin
        pix_q.push_back(WR_DATA);
        if (pix_q.size() == 4) begin
          word_q.push_back({pix_q[3], pix_q[2], pix_q[1], pix_q[0]});
          pix_q.delete();
        end
      end
    end
  end

  typedef struct {
    logic        wv;
    logic [7:0]  d;
    logic        rr;
    logic        fl;
    logic        rv;
    logic [31:0] data;
    logic [4:0]  lvl;
    logic        wrdy;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [7:0] d, input logic rr, input logic fl);
    WR_VALID = wv;
    WR_DATA  = d;
    RD_READY = rr;
    FLUSH    = fl;
  endtask

  initial begin
    int  cnt;
    int  p;
    int  cyc;
    logic acc;

    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 32'h0,        5'd1, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 32'h0,        5'd2, 1'b1};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 32'h0,        5'd3, 1'b1};
    vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 32'h0,        5'd4, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h44332211, 5'd0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h44332211, 5'd0, 1'b1};
    vecs[6]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 32'h44332211, 5'd1, 1'b1};
    vecs[7]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 32'h44332211, 5'd2, 1'b1};
    vecs[8]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 32'h44332211, 5'd3, 1'b1};
    vecs[9]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 32'h44332211, 5'd4, 1'b1};
    vecs[10] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 5'd1, 1'b1};
    vecs[11] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 5'd2, 1'b1};
    vecs[12] = '{1'b1, 8'hA6, 1'b0, 1'b1, 1'b0, 32'hA3A2A1A0, 5'd0, 1'b1};
    vecs[13] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 32'hA3A2A1A0, 5'd1, 1'b1};
    vecs[14] = '{1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 32'hA3A2A1A0, 5'd2, 1'b1};
    vecs[15] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 32'hA3A2A1A0, 5'd3, 1'b1};
    vecs[16] = '{1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 32'hA3A2A1A0, 5'd4, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hB3B2B1B0, 5'd0, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'hB3B2B1B0, 5'd0, 1'b1};

    RST_N = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    check("reset_rd_valid", {63'h0, RD_VALID}, 64'h0);
    check("reset_rd_data",  {32'h0, RD_DATA},  64'h0);
    check("reset_level",    {59'h0, LEVEL},    64'h0);
    check("reset_wr_ready", {63'h0, WR_READY}, 64'h0);
    check("reset_overflow", {63'h0, OVERFLOW}, 64'h0);
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    check("release_wr_ready", {63'h0, WR_READY}, 64'h1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].wv, vecs[i].d, vecs[i].rr, vecs[i].fl);
      tick();
      check($sformatf("vec%0d_rd_valid", i), {63'h0, RD_VALID}, {63'h0, vecs[i].rv});
      check($sformatf("vec%0d_rd_data", i),  {32'h0, RD_DATA},  {32'h0, vecs[i].data});
      check($sformatf("vec%0d_level", i),    {59'h0, LEVEL},    {59'h0, vecs[i].lvl});
      check($sformatf("vec%0d_wr_ready", i), {63'h0, WR_READY}, {63'h0, vecs[i].wrdy});
    end

    // Fill to capacity with the consumer stalled, then free one word.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, cnt[7:0], 1'b0, 1'b0);
      acc = WR_READY;
      tick();
      if (acc) cnt++;
    end
    check("full_accepts",  cnt,                 64'd20);
    check("full_wr_ready", {63'h0, WR_READY},   64'h0);
    check("full_level",    {59'h0, LEVEL},      64'd16);
    check("full_overflow", {63'h0, OVERFLOW},   {63'h0, OVF_EN});
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    check("pop_wr_ready_before", {63'h0, WR_READY}, 64'h0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("refill_wr_ready", {63'h0, WR_READY}, 64'h1);
    check("refill_level",    {59'h0, LEVEL},    64'd12);
    check("refill_rd_valid", {63'h0, RD_VALID}, 64'h1);
    RD_READY = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("drain_empty",    {59'h0, LEVEL},    64'd0);
    check("drain_overflow", {63'h0, OVERFLOW}, {63'h0, OVF_EN});
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check("flush_overflow", {63'h0, OVERFLOW}, 64'h0);

    // Random valid/ready streaming across several pointer wraps.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_pops = 0;
    p = 0;
    cyc = 0;
    while ((p < 48 || n_pops < 12) && cyc < 2000) begin
      WR_VALID = (p < 48) && ($urandom_range(0, 1) == 1);
      WR_DATA  = p[7:0];
      RD_READY = ($urandom_range(0, 1) == 1);
      acc = WR_VALID && WR_READY;
      tick();
      if (acc) p++;
      cyc++;
    end
    check("wrap_timeout",     {63'h0, (cyc >= 2000)}, 64'h0);
    check("wrap_words",       n_pops,                 64'd12);
    check("wrap_queue_empty", word_q.size(),          64'd0);
    check("wrap_overflow",    {63'h0, OVERFLOW},      64'h0);

    // Asynchronous reset in the middle of a transfer.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_rd_valid_pre", {63'h0, RD_VALID}, 64'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_reset_rd_valid", {63'h0, RD_VALID}, 64'h0);
    check("mid_reset_rd_data",  {32'h0, RD_DATA},  64'h0);
    check("mid_reset_level",    {59'h0, LEVEL},    64'h0);
    check("mid_reset_wr_ready", {63'h0, WR_READY}, 64'h0);
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    check("mid_release_wr_ready", {63'h0, WR_READY}, 64'h1);
    tick();
    check("first_accept_level", {59'h0, LEVEL}, 64'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
